// File: rtl/unified_mem_responder_if.sv
// Fetch and load/store request/response bundle between the core and the
// unified memory responder.
interface unified_mem_responder_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_func3;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3,
      input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3,
      output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err
   );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-port unified I/D memory responder: one access per cycle, data wins
// arbitration unless fetch has been starved STARVE cycles in a row.
// RV32 load/store sizing, halfword-aligned fetch with top-word wrap.
module unified_mem_responder #(
   parameter int DEPTH  = 64,
   parameter int STARVE = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   unified_mem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

   logic [31:0]   mem_q [DEPTH];
   logic [CW-1:0] starve_q, starve_d;
   logic          starve_hit;

   logic          d_rvalid_q, d_err_q, if_rvalid_q, if_err_q;
   logic [31:0]   d_rdata_q, if_rdata_q;

   // data-side decode
   logic [AW-1:0] d_idx;
   logic [1:0]    lane;
   logic          d_oor, d_legal, d_mis, d_bad, d_wr;
   logic [31:0]   d_rw, d_sh, d_ld, d_rsp, d_wd;
   logic [3:0]    d_be;

   // fetch-side decode
   logic [AW-1:0] f_idx, f_idx1;
   logic          f_bad;
   logic [31:0]   f_word, f_rsp;

   // grants are combinational and forced low while in reset
   assign starve_hit = (starve_q == CW'(STARVE));
   assign bus.d_gnt  = rst & bus.d_req & ~(bus.if_req & starve_hit);
   assign bus.if_gnt = rst & bus.if_req & (~bus.d_req | starve_hit);

   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_err     = d_err_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_err    = if_err_q;

   // starvation counter: counts consecutive denied fetches, saturating
   always_comb begin
      starve_d = starve_q;
      if (!bus.if_req || bus.if_gnt) starve_d = '0;
      else if (!starve_hit)          starve_d = starve_q + CW'(1);
   end

   // load/store decode: legality, alignment, extension and byte lanes
   always_comb begin
      d_idx   = bus.d_addr[AW+1:2];
      lane    = bus.d_addr[1:0];
      d_oor   = |bus.d_addr[31:AW+2];
      d_rw    = mem_q[d_idx];
      case (bus.d_func3)
         3'b000, 3'b001, 3'b010: d_legal = 1'b1;
         3'b100, 3'b101:         d_legal = ~bus.d_we;
         default:                d_legal = 1'b0;
      endcase
      d_mis   = ((bus.d_func3[1:0] == 2'b01) & lane[0]) |
                ((bus.d_func3[1:0] == 2'b10) & (|lane));
      d_bad   = d_oor | ~d_legal | d_mis;
      d_sh    = d_rw >> {lane, 3'b000};
      case (bus.d_func3[1:0])
         2'b00:   d_ld = bus.d_func3[2] ? {24'h0, d_sh[7:0]}  : {{24{d_sh[7]}}, d_sh[7:0]};
         2'b01:   d_ld = bus.d_func3[2] ? {16'h0, d_sh[15:0]} : {{16{d_sh[15]}}, d_sh[15:0]};
         default: d_ld = d_rw;
      endcase
      d_rsp   = (d_bad | bus.d_we) ? 32'h0 : d_ld;
      case (bus.d_func3[1:0])
         2'b00: begin
            d_be = 4'b0001 << lane;
            d_wd = {4{bus.d_wdata[7:0]}};
         end
         2'b01: begin
            d_be = 4'b0011 << lane;
            d_wd = {2{bus.d_wdata[15:0]}};
         end
         default: begin
            d_be = 4'b1111;
            d_wd = bus.d_wdata;
         end
      endcase
      d_wr    = bus.d_gnt & bus.d_we & ~d_bad;
   end

   // fetch decode: odd addresses fault, a halfword offset straddles two words
   always_comb begin
      f_idx  = bus.if_addr[AW+1:2];
      f_idx1 = f_idx + AW'(1);
      f_bad  = (|bus.if_addr[31:AW+2]) | bus.if_addr[0];
      f_word = bus.if_addr[1] ? {mem_q[f_idx1][15:0], mem_q[f_idx][31:16]} : mem_q[f_idx];
      f_rsp  = f_bad ? 32'h0 : f_word;
   end

   // storage is not reset; stores land at the accepting edge
   always_ff @(posedge clk) begin
      if (d_wr) begin
         for (int b = 0; b < 4; b++)
            if (d_be[b]) mem_q[d_idx][b*8 +: 8] <= d_wd[b*8 +: 8];
      end
   end

   // response registers; rdata/err only change when a new access is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q    <= '0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= 32'h0;
         d_err_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         if_err_q    <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         d_rvalid_q  <= bus.d_gnt;
         if_rvalid_q <= bus.if_gnt;
         if (bus.d_gnt) begin
            d_rdata_q <= d_rsp;
            d_err_q   <= d_bad;
         end
         if (bus.if_gnt) begin
            if_rdata_q <= f_rsp;
            if_err_q   <= f_bad;
         end
      end
   end
endmodule
